// File: rtl/spi_pkg.sv
// Shared SPI definitions: register maps for master and slave, slave STATUS layout,
// frame size and slave state encoding.
package spi_pkg;

    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
    localparam int unsigned ADDR_W     = 2;
    localparam int unsigned DATA_W     = 32;

    // spi_master register map
    localparam logic [ADDR_W-1:0] SLAVE_SELECT = 2'd0;
    localparam logic [ADDR_W-1:0] DATA_OUT     = 2'd1;
    localparam logic [ADDR_W-1:0] DATA_IN      = 2'd2;

    // spi_slave register map
    localparam logic [ADDR_W-1:0] STATUS  = 2'd0;
    localparam logic [ADDR_W-1:0] RX_DATA = 2'd1;
    localparam logic [ADDR_W-1:0] TX_DATA = 2'd2;
    localparam logic [ADDR_W-1:0] CONTROL = 2'd3;

    localparam int unsigned ST_RX_VALID   = 0;
    localparam int unsigned ST_OVERRUN    = 1;
    localparam int unsigned ST_TX_PENDING = 2;
    localparam int unsigned ST_BUSY       = 3;
    localparam int unsigned ST_ABORT      = 4;

    // Field order matches the ST_* bit indices (abort is the MSB).
    typedef struct packed {
        logic abort;
        logic busy;
        logic tx_pending;
        logic overrun;
        logic rx_valid;
    } status_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } slave_state_e;

    function automatic logic [DATA_W-1:0] status_word(input status_t s);
        return DATA_W'(s);
    endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Two-flop synchroniser for an asynchronous input with registered-level edge pulses.
module spi_input_sync #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level  = sync;
    assign rise_c = sync & ~prev;
    assign fall_c = ~sync & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI slave (CPHA=0, LSB first, 32-bit frames) with an Avalon-MM register file.
// Define SPI_SLAVE_IRQ_EN to add the irq port and CONTROL.irq_en.
module spi_slave
    import spi_pkg::*;
#(
    parameter bit CPOL = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss_n,
    output logic              miso,
    output logic              miso_oe,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    output logic [DATA_W-1:0] avs_readdata,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata
`ifdef SPI_SLAVE_IRQ_EN
    ,
    output logic              irq
`endif
);

    logic sclk_rise_c;
    logic sclk_fall_c;
    logic ss_rise_c;
    logic ss_fall_c;
    logic mosi_s;
    logic unused_sclk_level;
    logic unused_ss_level;
    logic unused_mosi_rise;
    logic unused_mosi_fall;
    logic unused_rx_msb;

    slave_state_e          state;
    status_t               st;
    logic [DATA_W-1:0]     rx_data;
    logic [DATA_W-1:0]     tx_buf;
    logic [FRAME_BITS-1:0] rx_shift;
    logic [FRAME_BITS-1:0] tx_shift;
    logic [CNT_W-1:0]      bit_cnt;
`ifdef SPI_SLAVE_IRQ_EN
    logic                  irq_en;
`endif

    logic                  lead_c;
    logic                  trail_c;
    logic                  rd_rx_c;
    logic                  wr_c;
    logic                  last_bit_c;
    logic [CNT_W-1:0]      next_cnt_c;
    logic [FRAME_BITS-1:0] tx_load_c;
    logic [FRAME_BITS-1:0] rx_word_c;

    spi_input_sync #(.RESET_VAL(CPOL)) u_sclk_sync (
        .clk    (clk),
        .reset  (reset),
        .d      (sclk),
        .level  (unused_sclk_level),
        .rise_c (sclk_rise_c),
        .fall_c (sclk_fall_c)
    );

    spi_input_sync #(.RESET_VAL(1'b1)) u_ss_sync (
        .clk    (clk),
        .reset  (reset),
        .d      (ss_n),
        .level  (unused_ss_level),
        .rise_c (ss_rise_c),
        .fall_c (ss_fall_c)
    );

    spi_input_sync #(.RESET_VAL(1'b0)) u_mosi_sync (
        .clk    (clk),
        .reset  (reset),
        .d      (mosi),
        .level  (mosi_s),
        .rise_c (unused_mosi_rise),
        .fall_c (unused_mosi_fall)
    );

    // The final bit is taken straight from mosi_s, so rx_shift's MSB is never read back.
    assign unused_rx_msb = rx_shift[FRAME_BITS-1];

    always_comb begin
        lead_c     = CPOL ? sclk_fall_c : sclk_rise_c;
        trail_c    = CPOL ? sclk_rise_c : sclk_fall_c;
        rd_rx_c    = avs_read && (avs_address == RX_DATA);
        wr_c       = avs_write && !avs_read;
        last_bit_c = (bit_cnt == CNT_W'(FRAME_BITS - 1));
        next_cnt_c = bit_cnt + CNT_W'(1);
        tx_load_c  = st.tx_pending ? tx_buf : '0;
        rx_word_c  = {mosi_s, rx_shift[FRAME_BITS-2:0]};
    end

    // Bus updates come first so FSM-raised flags win over same-cycle clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            st           <= '0;
            rx_data      <= '0;
            tx_buf       <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            bit_cnt      <= '0;
            miso         <= 1'b0;
            miso_oe      <= 1'b0;
            avs_readdata <= '0;
`ifdef SPI_SLAVE_IRQ_EN
            irq_en       <= 1'b0;
            irq          <= 1'b0;
`endif
        end else begin
            if (avs_read) begin
                case (avs_address)
                    STATUS:  avs_readdata <= status_word(st);
                    RX_DATA: avs_readdata <= rx_data;
                    TX_DATA: avs_readdata <= tx_buf;
`ifdef SPI_SLAVE_IRQ_EN
                    CONTROL: avs_readdata <= DATA_W'(irq_en);
`else
                    CONTROL: avs_readdata <= '0;
`endif
                    default: avs_readdata <= '0;
                endcase
            end

            if (rd_rx_c) begin
                st.rx_valid <= 1'b0;
            end

            if (wr_c) begin
                case (avs_address)
                    STATUS: begin
                        if (avs_writedata[ST_OVERRUN]) st.overrun <= 1'b0;
                        if (avs_writedata[ST_ABORT])   st.abort   <= 1'b0;
                    end
                    TX_DATA: tx_buf <= avs_writedata;
`ifdef SPI_SLAVE_IRQ_EN
                    CONTROL: irq_en <= avs_writedata[0];
`endif
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (ss_fall_c) begin
                        tx_shift      <= tx_load_c;
                        st.tx_pending <= 1'b0;
                        miso          <= tx_load_c[0];
                        miso_oe       <= 1'b1;
                        bit_cnt       <= '0;
                        st.busy       <= 1'b1;
                        state         <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ss_rise_c) begin
                        st.abort <= 1'b1;
                        st.busy  <= 1'b0;
                        miso_oe  <= 1'b0;
                        state    <= IDLE;
                    end else if (lead_c) begin
                        rx_shift[bit_cnt] <= mosi_s;
                        if (last_bit_c) begin
                            rx_data     <= rx_word_c;
                            st.rx_valid <= 1'b1;
                            if (st.rx_valid && !rd_rx_c) st.overrun <= 1'b1;
                            state       <= DONE;
                        end
                    end else if (trail_c) begin
                        bit_cnt <= next_cnt_c;
                        miso    <= tx_shift[next_cnt_c];
                    end
                end
                DONE: begin
                    if (ss_rise_c) begin
                        miso_oe <= 1'b0;
                        st.busy <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A TX_DATA write in the frame-start cycle stays pending for the next frame.
            if (wr_c && (avs_address == TX_DATA)) begin
                st.tx_pending <= 1'b1;
            end

`ifdef SPI_SLAVE_IRQ_EN
            irq <= irq_en & (st.rx_valid | st.overrun | st.abort);
`endif
        end
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave (target) with an Avalon-MM register interface; the peer of the team's spi_master on the same bus protocol.
- Receives 32-bit LSB-first frames on mosi and returns a preloaded 32-bit word on miso.
- Oversamples sclk, ss_n and mosi in the local clk domain; software reads received words and loads reply words through four registers.

Parameters:
- CPOL, 0, idle level of sclk. Leading edge is rising when 0, falling when 1.
- FRAME_BITS, 32, bits per frame. Fixed at 32; any other value is unsupported.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- sclk  input  1  SPI serial clock from master (asynchronous to clk)
- mosi  input  1  serial data from master
- ss_n  input  1  slave select, active low
- miso  output  1  serial data to master
- miso_oe  output  1  miso output enable; 1 only while selected
- avs_address  input  2  register select
- avs_read  input  1  read strobe
- avs_readdata  output  32  registered read data
- avs_write  input  1  write strobe
- avs_writedata  input  32  write data
- irq  output  1  level interrupt; exists only when SPI_SLAVE_IRQ_EN is defined

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high.
- Reset values: miso=0, miso_oe=0, avs_readdata=0, irq=0. All status bits, rx_data, tx_buf, the shift registers and bit_cnt are 0. State is IDLE.
- Input synchronisation:
  - sclk, ss_n and mosi each pass through a 2-FF synchroniser; sclk and ss_n are then edge-detected.
  - Required clocking: each sclk level lasts at least 2 clk periods. This matches the spi_master with SPI_CLK_DIV=2 on an equal clock.
- Frame format: SPI mode with CPHA=0, LSB first, FRAME_BITS bits per frame.
  - mosi is sampled on the leading edge.
  - miso changes on the trailing edge.
- Registers:
  - 0 STATUS: read bit0 rx_valid, bit1 overrun, bit2 tx_pending, bit3 busy, bit4 abort. A write with 1 clears bit1 and bit4 (write-1-to-clear); other bits are read-only.
  - 1 RX_DATA: read returns rx_data and clears rx_valid. Writes are ignored.
  - 2 TX_DATA: write loads tx_buf and sets tx_pending. Read returns tx_buf.
  - 3 CONTROL: bit0 irq_en (only with macro); otherwise reads 0 and writes are ignored.
- Bus timing: avs_readdata updates 1 cycle after avs_read. Read takes priority over write when both are asserted (write is dropped).
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on synced ss_n fall:
    - tx_shift <= tx_pending ? tx_buf : 0; tx_pending <= 0.
    - miso <= bit0 of the loaded word; miso_oe <= 1; bit_cnt <= 0; busy <= 1.
  - SHIFT:
    - Leading edge: rx_shift[bit_cnt] <= synced mosi.
    - Trailing edge: bit_cnt++; miso <= tx_shift[bit_cnt+1].
    - After the sample with bit_cnt==31: rx_data <= complete word; rx_valid <= 1; go to DONE.
  - DONE: further sclk edges are ignored and miso holds. Go to IDLE on synced ss_n rise, with miso_oe <= 0 and busy <= 0.
- Overrun: if rx_valid is already 1 at frame completion and no RX_DATA read occurs in that cycle, set overrun and overwrite rx_data with the new word.
- Read/complete collision: a frame completing in the same cycle as an RX_DATA read leaves rx_valid=1 with the new data, and no overrun. The read returns the old word.
- Abort: ss_n rises in SHIFT before 32 bits.
  - Partial word is discarded; rx_data and rx_valid are unchanged.
  - abort <= 1; go to IDLE with miso_oe <= 0.
- TX underrun: a frame starting with tx_pending=0 transmits 0; no flag is raised.
- TX write during a frame: updates tx_buf for the next frame only.
- sclk edges while ss_n is high are ignored.
- Reset mid-frame: immediate return to reset values; miso_oe drops asynchronously.

Optional Feature:
- Macro: SPI_SLAVE_IRQ_EN.
- Defined:
  - irq port and CONTROL.irq_en exist.
  - irq = irq_en & (rx_valid | overrun | abort), registered, asserted 1 cycle after the causing flag.
- Undefined: no irq port; CONTROL reads 0; all other behaviour is identical.

Decomposition:
- Package spi_pkg holds:
  - register address constants (SLAVE_SELECT/DATA_IN/DATA_OUT for the master, STATUS/RX_DATA/TX_DATA/CONTROL for the slave);
  - STATUS bit indices;
  - FRAME_BITS;
  - slave state enum {IDLE, SHIFT, DONE}.
- Sub-module spi_input_sync: 2-FF synchroniser plus rise/fall pulse outputs. Instantiated for sclk and ss_n; mosi uses the synchroniser only.

Test Plan:
- TX_DATA=0xA5A5_0F0F, then master sends 0x1234_5678 -> RX_DATA reads 0x1234_5678; master receives 0xA5A5_0F0F; STATUS reads 0x01 after the frame and 0x00 after the RX_DATA read.
- Two frames (0x1, 0x2) with no RX_DATA read in between -> STATUS=0x03, RX_DATA=0x2. Writing STATUS 0x02 then gives STATUS=0x01.
- ss_n deasserted after 10 sclk cycles -> abort=1; rx_valid=0; RX_DATA unchanged (0); the next full frame 0xDEAD_BEEF is received correctly.
- Frame with no TX_DATA write -> master receives 0x0000_0000; miso_oe is 0 before ss_n falls and after ss_n rises.
- RX_DATA read issued in the exact cycle of frame completion -> read returns the previous word; rx_valid stays 1; overrun stays 0.
- With SPI_SLAVE_IRQ_EN and CONTROL=1: irq rises 1 cycle after frame completion and falls 1 cycle after the RX_DATA read. Reset asserted mid-frame -> irq=0 and miso_oe=0 immediately.
